// File: rtl/priority_arbiter.sv
// Registered priority arbiter: fixed or round-robin selection, grants held until
// release or hold timeout, then a one-cycle gap before the next arbitration.
module priority_arbiter #(
  parameter int NUM_REQ   = 8,
  parameter int IDX_WIDTH = $clog2(NUM_REQ),
  parameter int MAX_HOLD  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic                 done,
  input  logic                 rr_mode,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 grant_valid,
  output logic                 timeout
);

  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     hold_cnt, cnt_d;
  logic [IDX_WIDTH-1:0] last_idx, last_d;
  logic [NUM_REQ-1:0]   grant_d;
  logic [IDX_WIDTH-1:0] idx_d;
  logic                 timeout_d;
  logic                 release_c;

  logic [IDX_WIDTH-1:0] top_idx, below_idx, win_idx;
  logic                 below_hit;

  // Ascending scan: the last matching index assigned is the highest one.
  always_comb begin
    top_idx   = '0;
    below_idx = '0;
    below_hit = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        top_idx = IDX_WIDTH'(i);
        if (i < int'(last_idx)) begin
          below_idx = IDX_WIDTH'(i);
          below_hit = 1'b1;
        end
      end
    end
    win_idx = (rr_mode && below_hit) ? below_idx : top_idx;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state;
    cnt_d     = hold_cnt;
    last_d    = last_idx;
    grant_d   = grant;
    idx_d     = grant_idx;
    timeout_d = 1'b0;
    release_c = done || !req[grant_idx];
    case (state)
      IDLE: begin
        if (|req) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          idx_d            = win_idx;
          last_d           = win_idx;
          cnt_d            = '0;
          state_d          = GRANT;
        end
      end
      GRANT: begin
        if (release_c) begin
          grant_d = '0;
          idx_d   = '0;
          state_d = GAP;
        end else if (MAX_HOLD > 0 && hold_cnt == HOLD_LAST) begin
          grant_d   = '0;
          idx_d     = '0;
          timeout_d = 1'b1;
          state_d   = GAP;
        end else if (hold_cnt != '1) begin
          cnt_d = hold_cnt + 1'b1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      last_idx  <= '0;
      grant     <= '0;
      grant_idx <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_d;
      hold_cnt  <= cnt_d;
      last_idx  <= last_d;
      grant     <= grant_d;
      grant_idx <= idx_d;
      timeout   <= timeout_d;
    end
  end

  assign grant_valid = |grant;

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed self-checking bench for priority_arbiter (NUM_REQ=8, MAX_HOLD=16).
module tb_priority_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] req;
  logic       done;
  logic       rr_mode;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  priority_arbiter #(.NUM_REQ(8), .MAX_HOLD(16)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done), .rr_mode(rr_mode),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected grant is one-hot of idx when valid, else zero with idx 0.
  task automatic expect_out(input string tag, input logic valid, input logic [2:0] idx,
                            input logic to);
    logic [7:0] g;
    g = valid ? (8'd1 << idx) : 8'd0;
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".idx"}, 32'(grant_idx), valid ? 32'(idx) : 32'd0);
    check({tag, ".valid"}, 32'(grant_valid), 32'(valid));
    check({tag, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  initial begin
    logic [2:0] rr_seq [5];
    rr_seq[0] = 3'd7; rr_seq[1] = 3'd2; rr_seq[2] = 3'd0; rr_seq[3] = 3'd7; rr_seq[4] = 3'd2;

    // Reset held 3 cycles with all requests up
    reset_n = 1'b0; req = 8'hFF; done = 1'b0; rr_mode = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("reset", 1'b0, 3'd0, 1'b0);
    end
    reset_n = 1'b1; req = 8'h00;
    tick(); expect_out("idle0", 1'b0, 3'd0, 1'b0);
    tick(); expect_out("idle1", 1'b0, 3'd0, 1'b0);

    // Fixed priority
    req = 8'b0010_0110;
    tick(); expect_out("fix.g1", 1'b1, 3'd5, 1'b0);
    tick(); expect_out("fix.g2", 1'b1, 3'd5, 1'b0);
    done = 1'b1;
    tick(); expect_out("fix.rel", 1'b0, 3'd0, 1'b0);
    done = 1'b0;
    tick(); expect_out("fix.gap", 1'b0, 3'd0, 1'b0);
    tick(); expect_out("fix.regrant", 1'b1, 3'd5, 1'b0);
    req = 8'h00;
    tick(); expect_out("fix.drop", 1'b0, 3'd0, 1'b0);
    tick(); expect_out("fix.idle", 1'b0, 3'd0, 1'b0);

    // Round-robin from a fresh last_idx
    reset_n = 1'b0;
    tick(); expect_out("rr.reset", 1'b0, 3'd0, 1'b0);
    reset_n = 1'b1; rr_mode = 1'b1; req = 8'b1000_0101;
    for (int k = 0; k < 5; k++) begin
      tick(); expect_out($sformatf("rr%0d.g1", k), 1'b1, rr_seq[k], 1'b0);
      tick(); expect_out($sformatf("rr%0d.g2", k), 1'b1, rr_seq[k], 1'b0);
      done = 1'b1;
      tick(); expect_out($sformatf("rr%0d.gap", k), 1'b0, 3'd0, 1'b0);
      done = 1'b0;
      tick(); expect_out($sformatf("rr%0d.idle", k), 1'b0, 3'd0, 1'b0);
    end
    req = 8'h00;
    tick(); expect_out("rr.end", 1'b0, 3'd0, 1'b0);

    // Timeout: grant held exactly 16 cycles
    rr_mode = 1'b0; req = 8'h08;
    for (int c = 1; c <= 16; c++) begin
      tick(); expect_out($sformatf("to.hold%0d", c), 1'b1, 3'd3, 1'b0);
    end
    tick(); expect_out("to.pulse", 1'b0, 3'd0, 1'b1);
    tick(); expect_out("to.after", 1'b0, 3'd0, 1'b0);
    tick(); expect_out("to.regrant", 1'b1, 3'd3, 1'b0);

    // done on the 16th cycle beats the timeout
    for (int c = 2; c <= 16; c++) begin
      tick(); check($sformatf("sim.hold%0d", c), 32'(grant), 32'h08);
    end
    done = 1'b1;
    tick(); expect_out("sim.rel", 1'b0, 3'd0, 1'b0);
    done = 1'b0;
    tick(); expect_out("sim.gap", 1'b0, 3'd0, 1'b0);
    tick(); expect_out("sim.g", 1'b1, 3'd3, 1'b0);

    // req drop together with done: one release, one gap cycle
    req = 8'h00; done = 1'b1;
    tick(); expect_out("both.rel", 1'b0, 3'd0, 1'b0);
    done = 1'b0; req = 8'h08;
    tick(); expect_out("both.gap", 1'b0, 3'd0, 1'b0);
    tick(); expect_out("both.regrant", 1'b1, 3'd3, 1'b0);
    req = 8'h00;
    tick(); expect_out("both.drop", 1'b0, 3'd0, 1'b0);
    tick(); expect_out("both.idle", 1'b0, 3'd0, 1'b0);

    // Reset mid-grant, then round-robin must restart from last_idx = 0
    req = 8'h40;
    tick(); expect_out("mid.g1", 1'b1, 3'd6, 1'b0);
    tick(); expect_out("mid.g2", 1'b1, 3'd6, 1'b0);
    reset_n = 1'b0;
    tick(); expect_out("mid.reset", 1'b0, 3'd0, 1'b0);
    reset_n = 1'b1; rr_mode = 1'b1; req = 8'b0100_0001;
    tick(); expect_out("mid.rr", 1'b1, 3'd6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/priority_arbiter.md
Name: priority_arbiter

Overview:
- Sequential arbiter that shares one resource among NUM_REQ requesters.
- Selection is priority-encoded with the highest index winning; an optional round-robin mode rotates priority.
- Output is a registered one-hot grant plus its binary index, so it can drive a downstream decoder or mux select.
- Grants are held until the owner releases or a hold timeout expires.

Parameters:
- NUM_REQ, 8, number of requesters (at least 2).
- IDX_WIDTH, $clog2(NUM_REQ), width of grant_idx.
- MAX_HOLD, 16, maximum cycles a grant may be held; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- req  input  NUM_REQ  request vector, level-sensitive; bit i is requester i.
- done  input  1  current owner releases the grant; one-cycle pulse.
- rr_mode  input  1  0 = fixed priority, 1 = round-robin.
- grant  output  NUM_REQ  registered one-hot grant; all zeros when no owner.
- grant_idx  output  IDX_WIDTH  binary index of the owner; valid only while grant_valid = 1.
- grant_valid  output  1  high while a grant is active (equals |grant).
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (reset_n = 0 at a clk edge):
  - grant, grant_idx, grant_valid and timeout all go to 0.
  - State goes to IDLE, hold_cnt to 0, last_idx to 0.
  - Reset during GRANT drops the grant at that same edge; no timeout pulse is produced.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If |req at edge N: latch the winner. grant, grant_idx and grant_valid are visible in the cycle after edge N (1-cycle latency). hold_cnt goes to 0 and the state goes to GRANT.
  - Otherwise stay in IDLE with outputs at 0.
- Winner selection, evaluated in IDLE only; rr_mode is sampled at that same edge:
  - Fixed mode: the highest set index of req.
  - Round-robin mode: the highest set index strictly below last_idx. If none exists, the highest set index overall.
  - last_idx is updated to the winner on every grant, in both modes.
- GRANT:
  - grant, grant_idx and grant_valid are held stable.
  - hold_cnt increments each cycle, saturating, width $clog2(MAX_HOLD+1).
  - Release occurs when done = 1 OR req[grant_idx] = 0. At that edge the grant outputs clear and the state goes to GAP.
  - Timeout (MAX_HOLD > 0): when hold_cnt = MAX_HOLD-1 with no release condition, the grant clears, timeout = 1 for exactly one cycle, and the state goes to GAP. The grant is therefore high for exactly MAX_HOLD cycles.
  - Simultaneous release condition and timeout: release wins and timeout stays 0.
  - Requests on other bits during GRANT are ignored; there is no preemption.
- GAP:
  - Exactly one cycle with outputs at 0, then unconditionally to IDLE.
  - Back-to-back grants therefore have 2 grant-low cycles between them: the GAP cycle and the IDLE arbitration cycle.
- done while in IDLE or GAP is ignored.
- Invariants:
  - grant is always one-hot or zero.
  - grant == (1 << grant_idx) whenever grant_valid = 1.
  - grant_idx = 0 when grant_valid = 0.

Test Plan:
- Reset/idle: hold reset_n = 0 for 3 cycles with req = 8'hFF, release reset with req = 0 → all outputs 0 and timeout never pulses.
- Fixed priority: rr_mode = 0, req = 8'b0010_0110 → one cycle later grant = 8'b0010_0000 and grant_idx = 5. Pulse done → grant = 0 for 2 cycles, then grant_idx = 5 again since req is unchanged.
- Round-robin rotation: rr_mode = 1, req = 8'b1000_0101 held, done pulsed on each grant's second cycle → grant_idx sequence 7, 2, 0, 7, 2. Each grant is separated by 2 zero cycles.
- Timeout: MAX_HOLD = 16, req[3] held, no done → grant_idx = 3 for exactly 16 cycles. timeout pulses 1 cycle on the edge where the grant drops, then 2 zero cycles, then grant_idx = 3 again.
- Simultaneous events: done asserted on the 16th grant cycle → grant drops and timeout stays 0. Separately, req[grant_idx] deasserting while done = 1 → single release and one GAP cycle.
- Reset mid-grant: reset_n = 0 while grant_idx = 6 → outputs 0 after that edge with no timeout pulse. After reset release in rr_mode = 1 with req = 8'b0100_0001 → grant_idx = 6, because last_idx was reset to 0.
